// File: rtl/interrupt_unit_if.sv
// Bus between the pipeline control and the interrupt unit.
// The pipeline side drives requests, stalls and the return address. The unit drives the PC steering and the CCR pulses.
interface interrupt_unit_if;
  logic       int_req;
  logic       RTI_dec;
  logic       stall;
  logic [7:0] pc_next;
  logic       interruptD;
  logic       RTI_en;
  logic       flush;
  logic [1:0] pc_sel;
  logic [7:0] vec_pc;
  logic [7:0] ret_pc;
  logic       int_ack;
  logic       in_service;

  modport master (
    output int_req, RTI_dec, stall, pc_next,
    input  interruptD, RTI_en, flush, pc_sel, vec_pc, ret_pc, int_ack, in_service
  );

  modport slave (
    input  int_req, RTI_dec, stall, pc_next,
    output interruptD, RTI_en, flush, pc_sel, vec_pc, ret_pc, int_ack, in_service
  );
endinterface

// File: rtl/interrupt_unit.sv
// Single-level, edge-triggered interrupt sequencer for the 8-bit pipeline.
// It flushes the pipeline, saves the flags, vectors to the ISR, and returns on RTI.
module interrupt_unit #(
  parameter logic [7:0] VEC_ADDR = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  interrupt_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    SAVE    = 3'd2,
    VECTOR  = 3'd3,
    SERVICE = 3'd4,
    RETURN  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       int_q, int_d;
  logic       pending_q, pending_d;
  logic       arm_q, arm_d;
  logic [7:0] ret_pc_q, ret_pc_d;
  logic       int_edge;

  // arm_q masks edge detection for the first cycle after reset.
  // A request line already high through reset is then treated as a held level, not a new request.
  always_comb begin
    int_edge  = bus.int_req & ~int_q & arm_q;
    int_d     = bus.int_req;
    arm_d     = 1'b1;
    state_d   = state_q;
    pending_d = pending_q | int_edge;
    ret_pc_d  = ret_pc_q;
    if (!bus.stall) begin
      case (state_q)
        IDLE: begin
          if (pending_q | int_edge) begin
            state_d   = FLUSH;
            pending_d = 1'b0;
            ret_pc_d  = bus.pc_next;
          end
        end
        FLUSH:   state_d = SAVE;
        SAVE:    state_d = VECTOR;
        VECTOR:  state_d = SERVICE;
        SERVICE: if (bus.RTI_dec) state_d = RETURN;
        RETURN:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      int_q     <= 1'b0;
      pending_q <= 1'b0;
      arm_q     <= 1'b0;
      ret_pc_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      pending_q <= pending_d;
      arm_q     <= arm_d;
      ret_pc_q  <= ret_pc_d;
    end
  end

  // Moore decode, silenced during a stall and while reset is asserted.
  always_comb begin
    bus.flush      = 1'b0;
    bus.interruptD = 1'b0;
    bus.int_ack    = 1'b0;
    bus.RTI_en     = 1'b0;
    bus.in_service = 1'b0;
    bus.pc_sel     = 2'b00;
    bus.vec_pc     = VEC_ADDR;
    bus.ret_pc     = reset ? ret_pc_q : 8'h00;
    if (reset && !bus.stall) begin
      case (state_q)
        FLUSH: begin
          bus.flush      = 1'b1;
          bus.in_service = 1'b1;
        end
        SAVE: begin
          bus.interruptD = 1'b1;
          bus.int_ack    = 1'b1;
          bus.in_service = 1'b1;
        end
        VECTOR: begin
          bus.pc_sel     = 2'b01;
          bus.in_service = 1'b1;
        end
        SERVICE: bus.in_service = 1'b1;
        RETURN: begin
          bus.RTI_en = 1'b1;
          bus.pc_sel = 2'b10;
          bus.flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit.
// It runs a table of per-cycle vectors, then hand sequences for stall, nesting, reset and held-request cases.
module tb_interrupt_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n_intd;
  int   n_ack;

  interrupt_unit_if bus();

  interrupt_unit #(.VEC_ADDR(8'h01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {flush, interruptD, int_ack, RTI_en, in_service}
  typedef struct {
    logic       rst_n;
    logic       ireq;
    logic       rti;
    logic       stl;
    logic [7:0] pcn;
    logic [4:0] flags;
    logic [1:0] sel;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic r, input logic i, input logic t, input logic s,
                              input logic [7:0] p, input logic [4:0] f, input logic [1:0] sl,
                              input logic [7:0] rt);
    vec_t v;
    v.rst_n = r; v.ireq = i; v.rti = t; v.stl = s; v.pcn = p;
    v.flags = f; v.sel = sl; v.ret = rt;
    return v;
  endfunction

  function automatic logic [22:0] outs();
    return {bus.flush, bus.interruptD, bus.int_ack, bus.RTI_en, bus.in_service,
            bus.pc_sel, bus.vec_pc, bus.ret_pc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then settle to the falling edge where outputs are compared.
  task automatic drive(input logic r, input logic i, input logic t, input logic s, input logic [7:0] p);
    reset       = r;
    bus.int_req = i;
    bus.RTI_dec = t;
    bus.stall   = s;
    bus.pc_next = p;
    @(negedge clk);
    if (bus.interruptD === 1'b1) n_intd++;
    if (bus.int_ack === 1'b1) n_ack++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; n_intd = 0; n_ack = 0;
    reset = 1'b0; bus.int_req = 1'b0; bus.RTI_dec = 1'b0; bus.stall = 1'b0; bus.pc_next = 8'h00;

    tbl[0]  = mk(0, 0, 0, 0, 8'h00, 5'b00000, 2'b00, 8'h00);
    tbl[1]  = mk(0, 0, 0, 0, 8'h00, 5'b00000, 2'b00, 8'h00);
    tbl[2]  = mk(1, 0, 0, 0, 8'h00, 5'b00000, 2'b00, 8'h00);
    tbl[3]  = mk(1, 0, 0, 0, 8'h2A, 5'b00000, 2'b00, 8'h00);
    tbl[4]  = mk(1, 1, 0, 0, 8'h2A, 5'b00000, 2'b00, 8'h00);
    tbl[5]  = mk(1, 1, 0, 0, 8'h2A, 5'b10001, 2'b00, 8'h2A);
    tbl[6]  = mk(1, 1, 0, 0, 8'h2A, 5'b01101, 2'b00, 8'h2A);
    tbl[7]  = mk(1, 1, 0, 0, 8'h2A, 5'b00001, 2'b01, 8'h2A);
    tbl[8]  = mk(1, 1, 0, 0, 8'h55, 5'b00001, 2'b00, 8'h2A);
    tbl[9]  = mk(1, 0, 0, 0, 8'h55, 5'b00001, 2'b00, 8'h2A);
    tbl[10] = mk(1, 0, 1, 0, 8'h55, 5'b00001, 2'b00, 8'h2A);
    tbl[11] = mk(1, 0, 0, 0, 8'h55, 5'b10010, 2'b10, 8'h2A);
    tbl[12] = mk(1, 0, 1, 0, 8'h55, 5'b00000, 2'b00, 8'h2A);
    tbl[13] = mk(1, 0, 0, 0, 8'h55, 5'b00000, 2'b00, 8'h2A);

    #1;
    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].rst_n, tbl[k].ireq, tbl[k].rti, tbl[k].stl, tbl[k].pcn);
      check($sformatf("row%0d", k), {9'd0, outs()},
            {9'd0, tbl[k].flags, tbl[k].sel, 8'h01, tbl[k].ret});
      tick();
    end

    // Stall held in SAVE suppresses interruptD, then exactly one pulse.
    n_intd = 0; n_ack = 0;
    drive(1, 1, 0, 0, 8'h10); check("a_idle_flush", {31'd0, bus.flush}, 32'd0); tick();
    drive(1, 1, 0, 0, 8'h10); check("a_flush", {31'd0, bus.flush}, 32'd1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 1, 8'h10);
      check($sformatf("a_stall%0d", k),
            {25'd0, bus.interruptD, bus.int_ack, bus.flush, bus.in_service, bus.RTI_en, bus.pc_sel}, 32'd0);
      tick();
    end
    drive(1, 1, 0, 0, 8'h10); check("a_save_intd", {31'd0, bus.interruptD}, 32'd1); tick();
    drive(1, 1, 0, 0, 8'h10); check("a_vector", {22'd0, bus.pc_sel, bus.vec_pc}, {22'd0, 2'b01, 8'h01}); tick();
    check("a_intd_pulses", n_intd, 32'd1);

    // A new edge in the same cycle as RTI is serviced after one IDLE cycle.
    drive(1, 0, 0, 0, 8'h10); check("b_service", {31'd0, bus.in_service}, 32'd1); tick();
    drive(1, 1, 1, 0, 8'h33); tick();
    drive(1, 1, 0, 0, 8'h33);
    check("b_return", {20'd0, bus.RTI_en, bus.pc_sel, bus.flush, bus.ret_pc}, {20'd0, 1'b1, 2'b10, 1'b1, 8'h10});
    tick();
    drive(1, 1, 0, 0, 8'h44); check("b_idle", {30'd0, bus.flush, bus.in_service}, 32'd0); tick();
    drive(1, 1, 0, 0, 8'h44); check("b_reflush", {23'd0, bus.flush, bus.ret_pc}, {23'd0, 1'b1, 8'h44}); tick();
    drive(1, 1, 0, 0, 8'h44); tick();
    check("b_ack_pulses", n_ack, 32'd2);

    // Reset during VECTOR, then int_req held high gives no request.
    drive(0, 1, 0, 0, 8'h44); check("c_in_reset", {9'd0, outs()}, {9'd0, 5'b0, 2'b00, 8'h01, 8'h00}); tick();
    n_ack = 0;
    drive(1, 1, 0, 0, 8'h55); check("c_after_reset", {9'd0, outs()}, {9'd0, 5'b0, 2'b00, 8'h01, 8'h00}); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 8'h55);
      check($sformatf("c_held%0d", k), {30'd0, bus.flush, bus.in_service}, 32'd0);
      tick();
    end
    check("c_no_ack", n_ack, 32'd0);

    // A level held across a full service produces one request only.
    drive(1, 0, 0, 0, 8'h60); tick();
    n_ack = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, (k == 4), 0, 8'h60);
      if (k == 5) check("d_rti_en", {31'd0, bus.RTI_en}, 32'd1);
      tick();
    end
    check("d_one_ack", n_ack, 32'd1);
    drive(1, 1, 0, 0, 8'h60); check("d_idle_end", {30'd0, bus.flush, bus.in_service}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interrupt_unit.md
INTERRUPT_UNIT -- requirements
Module: interrupt_unit

Interface
REQ-001 SHALL have parameter VEC_ADDR, default 8'h01, interrupt service routine start address driven on vec_pc.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low; reset=0 at a clk rising edge resets the block.
REQ-004 SHALL have port int_req  input  1  external interrupt request line (level, rising edge significant).
REQ-005 SHALL have port RTI_dec  input  1  RTI instruction decoded this cycle.
REQ-006 SHALL have port stall  input  1  pipeline stall; FSM freezes while high.
REQ-007 SHALL have port pc_next  input  8  address of the next unexecuted instruction (return address).
REQ-008 SHALL have port interruptD  output  1  one-cycle pulse telling the CCR to save flags.
REQ-009 SHALL have port RTI_en  output  1  one-cycle pulse telling the CCR to restore flags.
REQ-010 SHALL have port flush  output  1  flush fetch/decode pipeline registers.
REQ-011 SHALL have port pc_sel  output  2  PC source: 00 normal, 01 vec_pc, 10 ret_pc, 11 unused.
REQ-012 SHALL have ports vec_pc  output  8  constant VEC_ADDR; ret_pc  output  8  saved return address.
REQ-013 SHALL have ports int_ack  output  1  request accepted pulse; in_service  output  1  handler active.

Function
REQ-014 SHALL register int_req into int_q each cycle; edge = int_req & ~int_q.
REQ-015 SHALL keep sticky pending bit: set by edge in any state, cleared on the IDLE->FLUSH transition.
REQ-016 SHALL implement states IDLE, FLUSH, SAVE, VECTOR, SERVICE, RETURN; all transitions require stall=0.
REQ-017 IDLE -> FLUSH when (pending | edge) and stall=0; ret_pc <= pc_next on that same edge.
REQ-018 FLUSH -> SAVE -> VECTOR -> SERVICE unconditionally, one cycle each when stall=0.
REQ-019 SERVICE -> RETURN when RTI_dec=1; RETURN -> IDLE after one cycle.
REQ-020 Outputs SHALL be Moore-decoded from state and forced to 0 (pc_sel 00) in any cycle with stall=1.
REQ-021 FLUSH: flush=1. SAVE: interruptD=1, int_ack=1. VECTOR: pc_sel=01. RETURN: RTI_en=1, pc_sel=10, flush=1.
REQ-022 in_service SHALL be 1 in FLUSH, SAVE, VECTOR, SERVICE; 0 in IDLE and RETURN.
REQ-023 Latency: int_req rising edge sampled at cycle t with no stall -> FLUSH t+1, interruptD t+2, pc_sel=01 t+3.
REQ-024 No nesting: edges during FLUSH..RETURN SHALL only set pending; serviced after returning to IDLE.
REQ-025 RTI_dec outside SERVICE SHALL be ignored (no RTI_en, no state change).
REQ-026 RTI_dec and a new edge in the same SERVICE cycle: RETURN taken, pending set, FLUSH re-entered from IDLE.
REQ-027 int_req held high SHALL produce exactly one request (edge-triggered).
REQ-028 ret_pc SHALL hold its value from capture until the next IDLE->FLUSH transition.

Reset
REQ-029 reset=0 SHALL set state=IDLE, int_q=0, pending=0, ret_pc=8'h00 on the next clk edge, overriding all other inputs, including mid-sequence.
REQ-030 While in reset and the cycle after, all outputs SHALL be 0, pc_sel=00, vec_pc=VEC_ADDR.

Verification
REQ-031 pc_next=8'h2A, int_req 0->1 at t, stall=0 -> flush t+1, interruptD+int_ack t+2, pc_sel=01/vec_pc=8'h01 t+3, ret_pc=8'h2A.
REQ-032 In SERVICE, RTI_dec=1 -> next cycle RTI_en=1, pc_sel=10, ret_pc=8'h2A, flush=1; then IDLE, in_service=0.
REQ-033 stall=1 for 3 cycles while in SAVE -> interruptD=0 during stall, exactly one interruptD pulse after stall drops.
REQ-034 Second int_req edge during SERVICE, then RTI -> RETURN, one IDLE cycle, new FLUSH; two int_ack pulses total.
REQ-035 reset=0 asserted in VECTOR -> next cycle IDLE, pc_sel=00, ret_pc=8'h00, pending=0; int_req held high after reset issues no request.
REQ-036 RTI_dec=1 while IDLE -> RTI_en stays 0, state stays IDLE.
